// File: rtl/align_w_split_pkg.sv
// -----------------------------------------------------------------------------
// align_w_split_pkg
//   Shared definitions for the write-side splitter and the read-side aligner:
//   FSM state type and the window/beat derivations, so that both blocks number
//   windows identically (window w = bytes [w*2^OUT +: 2^OUT]).
// -----------------------------------------------------------------------------
package align_w_split_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StSend = 1'b1
   } state_e;

   // Number of narrow windows inside one wide word.
   function automatic int unsigned win_num(input int unsigned in_lg,
                                           input int unsigned out_lg);
      return 32'd1 << (in_lg - out_lg);
   endfunction

   // Width of a window index; kept at least 1 so IN == OUT still has a signal.
   function automatic int unsigned win_idx_w(input int unsigned in_lg,
                                             input int unsigned out_lg);
      return (in_lg > out_lg) ? (in_lg - out_lg) : 32'd1;
   endfunction

endpackage

// File: rtl/priority_enc_lsb.sv
// -----------------------------------------------------------------------------
// priority_enc_lsb
//   Lowest-set-bit encoder over a pending-window mask.
//   i_pend    : pending window mask
//   o_onehot  : one-hot of the lowest set bit (0 if none)
//   o_idx     : index of the lowest set bit (0 if none)
//   o_any     : any bit set
//   o_last    : the lowest set bit is also the only/highest set bit
// -----------------------------------------------------------------------------
module priority_enc_lsb #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 1
) (
   input  logic [N-1:0] i_pend,
   output logic [N-1:0] o_onehot,
   output logic [W-1:0] o_idx,
   output logic         o_any,
   output logic         o_last
);

   // Scan downward so the lowest set bit wins.
   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_pend[i]) o_idx = W'(i);
      end
   end

   // Two's-complement trick isolates the lowest set bit.
   assign o_onehot = i_pend & (~i_pend + N'(1));
   assign o_any    = |i_pend;
   assign o_last   = ~|(i_pend & ~o_onehot);

endmodule

// File: rtl/align_w_split.sv
// -----------------------------------------------------------------------------
// align_w_split
//   Write-path width converter: takes one wide write (addr, data, byte-enables)
//   and emits it as narrow beats, skipping windows with no byte-enable set.
//   All outputs registered; no combinational path from i_ready to o_ready.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_valid/o_ready   upstream handshake
//   i_addr/i_dat/i_be upstream request (i_addr low IN bits ignored)
//   o_valid/i_ready   downstream handshake
//   o_addr/o_dat/o_be downstream beat
//   o_last            final beat of the current request
// -----------------------------------------------------------------------------
module align_w_split
   import align_w_split_pkg::*;
#(
   parameter int unsigned IN_P_DW_BYTES  = 3,
   parameter int unsigned OUT_P_DW_BYTES = 2,
   parameter int unsigned AW             = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_valid,
   output logic                              o_ready,
   input  logic [AW-1:0]                     i_addr,
   input  logic [(8 << IN_P_DW_BYTES)-1:0]   i_dat,
   input  logic [(1 << IN_P_DW_BYTES)-1:0]   i_be,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic [AW-1:0]                     o_addr,
   output logic [(8 << OUT_P_DW_BYTES)-1:0]  o_dat,
   output logic [(1 << OUT_P_DW_BYTES)-1:0]  o_be,
   output logic                              o_last
);

   localparam int unsigned IN_B     = 32'd1 << IN_P_DW_BYTES;
   localparam int unsigned OUT_B    = 32'd1 << OUT_P_DW_BYTES;
   localparam int unsigned OUT_BITS = OUT_B * 8;
   localparam int unsigned WIN_NUM  = win_num(IN_P_DW_BYTES, OUT_P_DW_BYTES);
   localparam int unsigned WIN_W    = win_idx_w(IN_P_DW_BYTES, OUT_P_DW_BYTES);
   localparam logic [AW-1:0] BASE_MASK = ~AW'(IN_B - 1);

   state_e               r_state,   w_state_nxt;
   logic                 r_ready,   w_ready_nxt;
   logic                 r_valid,   w_valid_nxt;
   logic                 r_last,    w_last_nxt;
   logic [AW-1:0]        r_oaddr,   w_oaddr_nxt;
   logic [OUT_BITS-1:0]  r_odat,    w_odat_nxt;
   logic [OUT_B-1:0]     r_obe,     w_obe_nxt;
   logic [AW-1:0]        r_base,    w_base_nxt;
   logic [IN_B*8-1:0]    r_dat,     w_dat_nxt;
   logic [IN_B-1:0]      r_be,      w_be_nxt;
   logic [WIN_NUM-1:0]   r_pend,    w_pend_nxt;
   logic [WIN_NUM-1:0]   r_cur_oh,  w_cur_oh_nxt;

   logic [WIN_NUM-1:0]   w_pend_in;
   logic [WIN_NUM-1:0]   w_enc_in;
   logic [WIN_NUM-1:0]   w_enc_oh;
   logic [WIN_W-1:0]     w_enc_idx;
   logic                 w_enc_any;
   logic                 w_enc_last;
   logic [IN_B*8-1:0]    w_src_dat;
   logic [IN_B-1:0]      w_src_be;
   logic [AW-1:0]        w_src_base;
   logic [OUT_BITS-1:0]  w_beat_dat;
   logic [OUT_B-1:0]     w_beat_be;
   logic                 w_load;

   // A window is pending iff any of its byte-enables is set.
   always_comb begin
      w_pend_in = '0;
      for (int w = 0; w < int'(WIN_NUM); w++) begin
         w_pend_in[w] = |i_be[w*OUT_B +: OUT_B];
      end
   end

   priority_enc_lsb #(
      .N (WIN_NUM),
      .W (WIN_W)
   ) u_enc (
      .i_pend   (w_enc_in),
      .o_onehot (w_enc_oh),
      .o_idx    (w_enc_idx),
      .o_any    (w_enc_any),
      .o_last   (w_enc_last)
   );

   // Window mux; the source is the live request when idle, latched copy otherwise.
   always_comb begin
      w_beat_dat = '0;
      w_beat_be  = '0;
      for (int w = 0; w < int'(WIN_NUM); w++) begin
         if (w_enc_idx == WIN_W'(w)) begin
            w_beat_dat = w_src_dat[w*OUT_BITS +: OUT_BITS];
            w_beat_be  = w_src_be[w*OUT_B +: OUT_B];
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ready_nxt  = r_ready;
      w_valid_nxt  = r_valid;
      w_last_nxt   = r_last;
      w_oaddr_nxt  = r_oaddr;
      w_odat_nxt   = r_odat;
      w_obe_nxt    = r_obe;
      w_base_nxt   = r_base;
      w_dat_nxt    = r_dat;
      w_be_nxt     = r_be;
      w_pend_nxt   = r_pend;
      w_cur_oh_nxt = r_cur_oh;
      w_enc_in     = r_pend & ~r_cur_oh;
      w_src_dat    = r_dat;
      w_src_be     = r_be;
      w_src_base   = r_base;
      w_load       = 1'b0;

      unique case (r_state)
         StIdle: begin
            w_enc_in    = w_pend_in;
            w_src_dat   = i_dat;
            w_src_be    = i_be;
            w_src_base  = i_addr & BASE_MASK;
            // First edge out of reset raises ready; all-zero requests are eaten here.
            w_ready_nxt = 1'b1;
            if (r_ready && i_valid && w_enc_any) begin
               w_state_nxt = StSend;
               w_ready_nxt = 1'b0;
               w_base_nxt  = i_addr & BASE_MASK;
               w_dat_nxt   = i_dat;
               w_be_nxt    = i_be;
               w_load      = 1'b1;
            end
         end
         StSend: begin
            if (r_valid && i_ready) begin
               if (w_enc_any) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = StIdle;
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
                  w_ready_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase

      if (w_load) begin
         w_valid_nxt  = 1'b1;
         w_oaddr_nxt  = w_src_base | (AW'(w_enc_idx) << OUT_P_DW_BYTES);
         w_odat_nxt   = w_beat_dat;
         w_obe_nxt    = w_beat_be;
         w_last_nxt   = w_enc_last;
         w_pend_nxt   = w_enc_in;
         w_cur_oh_nxt = w_enc_oh;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_ready  <= 1'b0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_oaddr  <= '0;
         r_odat   <= '0;
         r_obe    <= '0;
         r_base   <= '0;
         r_dat    <= '0;
         r_be     <= '0;
         r_pend   <= '0;
         r_cur_oh <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_ready  <= w_ready_nxt;
         r_valid  <= w_valid_nxt;
         r_last   <= w_last_nxt;
         r_oaddr  <= w_oaddr_nxt;
         r_odat   <= w_odat_nxt;
         r_obe    <= w_obe_nxt;
         r_base   <= w_base_nxt;
         r_dat    <= w_dat_nxt;
         r_be     <= w_be_nxt;
         r_pend   <= w_pend_nxt;
         r_cur_oh <= w_cur_oh_nxt;
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_valid;
   assign o_last  = r_last;
   assign o_addr  = r_oaddr;
   assign o_dat   = r_odat;
   assign o_be    = r_obe;

endmodule

// File: tb/tb_align_w_split.sv
// -----------------------------------------------------------------------------
// tb_align_w_split
//   Bench for align_w_split: a 64->32 instance (a_*) and a 32->32 instance
//   (b_*). Expected beats come from a byte-window model of the request.
// -----------------------------------------------------------------------------
module tb_align_w_split;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] dat;
      logic [3:0]  be;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_valid, a_ready, a_ovalid, a_iready, a_olast;
   logic [31:0] a_addr, a_oaddr, a_odat;
   logic [63:0] a_dat;
   logic [7:0]  a_be;
   logic [3:0]  a_obe;

   logic        b_valid, b_ready, b_ovalid, b_iready, b_olast;
   logic [31:0] b_addr, b_oaddr, b_dat, b_odat;
   logic [3:0]  b_be, b_obe;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   align_w_split #(
      .IN_P_DW_BYTES  (3),
      .OUT_P_DW_BYTES (2),
      .AW             (32)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (a_valid),
      .o_ready (a_ready),
      .i_addr  (a_addr),
      .i_dat   (a_dat),
      .i_be    (a_be),
      .o_valid (a_ovalid),
      .i_ready (a_iready),
      .o_addr  (a_oaddr),
      .o_dat   (a_odat),
      .o_be    (a_obe),
      .o_last  (a_olast)
   );

   align_w_split #(
      .IN_P_DW_BYTES  (2),
      .OUT_P_DW_BYTES (2),
      .AW             (32)
   ) dut_eq (
      .clk     (clk),
      .rst     (rst),
      .i_valid (b_valid),
      .o_ready (b_ready),
      .i_addr  (b_addr),
      .i_dat   (b_dat),
      .i_be    (b_be),
      .o_valid (b_ovalid),
      .i_ready (b_iready),
      .o_addr  (b_oaddr),
      .o_dat   (b_odat),
      .o_be    (b_obe),
      .o_last  (b_olast)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: each 4-byte window with any enable becomes one beat, in
   // ascending window order; the highest such window carries last.
   task automatic build_model(input logic [31:0] addr, input logic [63:0] dat,
                              input logic [7:0] be, output beat_t q[$]);
      int          hi;
      logic [31:0] base;
      logic [63:0] sh;
      logic [7:0]  bsh;
      beat_t       b;
      q    = {};
      hi   = -1;
      base = addr & 32'hFFFF_FFF8;
      for (int w = 0; w < 2; w++) begin
         bsh = be >> (4 * w);
         if (bsh[3:0] != 4'h0) hi = w;
      end
      for (int w = 0; w < 2; w++) begin
         bsh = be >> (4 * w);
         sh  = dat >> (32 * w);
         if (bsh[3:0] != 4'h0) begin
            b.addr = base + 32'(4 * w);
            b.dat  = sh[31:0];
            b.be   = bsh[3:0];
            b.last = (w == hi);
            q.push_back(b);
         end
      end
   endtask

   // Called and returns just after a falling edge.
   task automatic run_req(input string name, input logic [31:0] addr, input logic [63:0] dat,
                          input logic [7:0] be, input int stall, input int rdy_pct);
      beat_t q[$];
      beat_t b;
      int    budget;
      bit    done;
      build_model(addr, dat, be, q);
      budget = 0;
      while (!a_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check({name, "_accept_ready"}, a_ready, 1);
      a_valid  = 1'b1;
      a_addr   = addr;
      a_dat    = dat;
      a_be     = be;
      a_iready = 1'b0;
      @(negedge clk);
      a_valid = 1'b0;
      a_addr  = $urandom;
      a_dat   = {$urandom, $urandom};
      a_be    = 8'($urandom);
      if (q.size() > 0) begin
         check({name, "_first_valid"}, a_ovalid, 1);
         check({name, "_ready_low"}, a_ready, 0);
         for (int k = 0; k < stall; k++) begin
            a_iready = 1'b0;
            check({name, "_hold_addr"}, a_oaddr, q[0].addr);
            check({name, "_hold_dat"}, a_odat, q[0].dat);
            check({name, "_hold_be"}, a_obe, q[0].be);
            check({name, "_hold_last"}, a_olast, q[0].last);
            @(negedge clk);
         end
      end
      done = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         if (q.size() == 0 && !a_ovalid && a_ready) begin
            done = 1'b1;
         end else begin
            a_iready = ($urandom_range(99) < rdy_pct);
            if (a_ovalid && a_iready) begin
               if (q.size() == 0) begin
                  check({name, "_extra_beat"}, a_ovalid, 0);
               end else begin
                  b = q.pop_front();
                  check({name, "_addr"}, a_oaddr, b.addr);
                  check({name, "_dat"}, a_odat, b.dat);
                  check({name, "_be"}, a_obe, b.be);
                  check({name, "_last"}, a_olast, b.last);
               end
            end
            @(negedge clk);
         end
      end
      check({name, "_complete"}, done, 1);
      a_iready = 1'b0;
   endtask

   initial begin
      logic [31:0] r_addr;
      logic [63:0] r_dat;
      logic [7:0]  r_be;
      bit          seen;

      rst      = 1'b1;
      a_valid  = 1'b0; a_addr = '0; a_dat = '0; a_be = '0; a_iready = 1'b0;
      b_valid  = 1'b0; b_addr = '0; b_dat = '0; b_be = '0; b_iready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", a_ready, 0);
      check("rst_valid", a_ovalid, 0);
      check("rst_last", a_olast, 0);
      check("rst_addr", a_oaddr, 0);
      check("rst_dat", a_odat, 0);
      check("rst_be", a_obe, 0);
      rst = 1'b0;
      #1 check("ready_before_edge", a_ready, 0);
      @(negedge clk);
      check("ready_after_release", a_ready, 1);
      check("eq_ready_after_release", b_ready, 1);

      // Full write, upper-only, single byte lane.
      run_req("full", 32'h1000, 64'h11223344_55667788, 8'hFF, 0, 100);
      run_req("upper", 32'h1000, 64'h11223344_55667788, 8'hF0, 0, 100);
      run_req("lane", 32'h1000, 64'h11223344_55667788, 8'h0C, 0, 100);

      // All-zero enables: consumed silently, next request taken right after.
      run_req("zero", 32'h1000, 64'h11223344_55667788, 8'h00, 0, 100);
      check("zero_ready_stays", a_ready, 1);
      check("zero_no_valid", a_ovalid, 0);
      run_req("after_zero", 32'h2008, 64'hA5A5A5A5_5A5A5A5A, 8'h81, 0, 100);

      // Back-pressure on beat 0.
      run_req("stall", 32'h1000, 64'h11223344_55667788, 8'hFF, 3, 100);

      // Reset after beat 0 transfers: remaining beat must be dropped.
      a_valid = 1'b1; a_addr = 32'h1000; a_dat = 64'h11223344_55667788; a_be = 8'hFF;
      @(negedge clk);
      a_valid  = 1'b0;
      a_iready = 1'b1;
      check("rstmid_beat0_valid", a_ovalid, 1);
      check("rstmid_beat0_addr", a_oaddr, 32'h1000);
      @(negedge clk);
      a_iready = 1'b0;
      check("rstmid_beat1_addr", a_oaddr, 32'h1004);
      #2 rst = 1'b1;
      #1 check("rstmid_valid_drop", a_ovalid, 0);
      check("rstmid_ready_drop", a_ready, 0);
      check("rstmid_last_drop", a_olast, 0);
      @(negedge clk);
      rst      = 1'b0;
      a_iready = 1'b1;
      @(negedge clk);
      check("rstmid_ready_one_edge", a_ready, 1);
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (a_ovalid) seen = 1'b1;
         @(negedge clk);
      end
      check("rstmid_no_replay", seen, 0);
      a_iready = 1'b0;

      // Random requests with random back-pressure.
      for (int n = 0; n < 24; n++) begin
         r_addr = $urandom;
         r_dat  = {$urandom, $urandom};
         r_be   = (n % 6 == 5) ? 8'h00 : 8'($urandom_range(255));
         run_req("rand", r_addr, r_dat, r_be, 0, 60);
      end

      // IN == OUT: single pass-through beat.
      b_valid = 1'b1; b_addr = 32'h2004; b_dat = 32'hCAFEBABE; b_be = 4'h3;
      @(negedge clk);
      b_valid  = 1'b0;
      b_iready = 1'b1;
      check("eq_valid", b_ovalid, 1);
      check("eq_addr", b_oaddr, 32'h2004);
      check("eq_dat", b_odat, 32'hCAFEBABE);
      check("eq_be", b_obe, 4'h3);
      check("eq_last", b_olast, 1);
      check("eq_ready_low", b_ready, 0);
      @(negedge clk);
      b_iready = 1'b0;
      check("eq_valid_done", b_ovalid, 0);
      check("eq_ready_back", b_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
